camera_anim_controller: RTL and testbench

//  Frame-synchronous controller that sequences the pixel generator's per-frame state: camera_y, char_id and char_face.
//  - Once per frame it divides the character's centre Y by BLOCK_WIDTH with a multi-cycle subtract FSM.
//  - camera_y changes only after the target screen has been stable for SETTLE_FRAMES frames.
//  - Walk-animation index is advanced on frame ticks; replaces the free-running divider/counter stub.

---
 rtl/camera_anim_controller.sv | 163 ++++++++++++++++
 tb/tb_camera_anim_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_anim_controller.sv
// camera_anim_controller
//   Frame-synchronous sequencer for the pixel generator's per-frame state.
//   On each accepted frame_start it latches the character's centre Y, divides
//   it by BLOCK_WIDTH with a repeated-subtract FSM (IDLE -> DIVIDE -> COMMIT),
//   and moves camera_y only once the same target screen has been seen for
//   SETTLE_FRAMES consecutive frames. Facing and walk animation also advance
//   on accepted frame_start pulses.
//
// Ports
//   sys_clk        in   system clock
//   sys_rst_n      in   asynchronous active-low reset
//   frame_start    in   one-cycle pulse at start of vertical blanking
//   char_abs_y     in   character absolute Y (top edge), PHY_WIDTH bits
//   char_moving    in   1 = walking (animate), 0 = idle
//   char_dir       in   1 = facing right, 0 = facing left
//   camera_y       out  current screen index, CAM_WIDTH bits
//   char_id        out  walk animation frame index
//   char_face      out  2'b10 right, 2'b01 left
//   cam_update     out  one-cycle pulse when camera_y changes
//   busy           out  high while the FSM is not idle
//   frame_overrun  out  one-cycle pulse: frame_start arrived while busy
module camera_anim_controller #(
  parameter int unsigned PHY_WIDTH     = 14,
  parameter int unsigned BLOCK_WIDTH   = 480,
  parameter int unsigned CHAR_WIDTH_Y  = 52,
  parameter int unsigned CAM_WIDTH     = 5,
  parameter int unsigned CAM_MAX       = 31,
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned ANIM_LEN      = 7,
  parameter int unsigned ANIM_FRAMES   = 6
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 frame_start,
  input  logic [PHY_WIDTH-1:0] char_abs_y,
  input  logic                 char_moving,
  input  logic                 char_dir,
  output logic [CAM_WIDTH-1:0] camera_y,
  output logic [2:0]           char_id,
  output logic [1:0]           char_face,
  output logic                 cam_update,
  output logic                 busy,
  output logic                 frame_overrun
);

  localparam int unsigned RW = PHY_WIDTH + 1;
  localparam int unsigned SW = $clog2(SETTLE_FRAMES + 1);
  localparam int unsigned AW = $clog2(ANIM_FRAMES + 1);

  localparam logic [RW-1:0]        BLOCK_W   = RW'(BLOCK_WIDTH);
  localparam logic [RW-1:0]        HALF_H    = RW'(CHAR_WIDTH_Y / 2);
  localparam logic [CAM_WIDTH-1:0] QMAX      = CAM_WIDTH'(CAM_MAX);
  localparam logic [SW-1:0]        SETTLE    = SW'(SETTLE_FRAMES);
  localparam logic [AW-1:0]        ANIM_LAST = AW'(ANIM_FRAMES - 1);
  localparam logic [2:0]           ID_LAST   = 3'(ANIM_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    COMMIT
  } state_t;

  state_t state_q, state_d;

  logic [RW-1:0]        rem_q;
  logic [CAM_WIDTH-1:0] quot_q;
  logic [CAM_WIDTH-1:0] last_target_q;
  logic [SW-1:0]        stable_q;
  logic [AW-1:0]        anim_cnt_q;

  logic                 accept;
  logic                 div_step;
  logic                 target_match;
  logic [SW-1:0]        stable_next;
  logic                 cam_move;

  // Another subtraction is possible while the remainder still spans a screen
  // and the quotient has headroom; otherwise the quotient is final.
  assign div_step = (rem_q >= BLOCK_W) && (quot_q < QMAX);

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_start) state_d = DIVIDE;
      DIVIDE:  if (!div_step)   state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / decode logic
  always_comb begin
    busy   = (state_q != IDLE);
    accept = frame_start && (state_q == IDLE);
  end

  // Settle filter: count consecutive frames with the same target screen,
  // saturating so the counter cannot wrap during a long stable period.
  always_comb begin
    target_match = (quot_q == last_target_q);
    stable_next  = SW'(1);
    if (target_match) begin
      stable_next = (stable_q >= SETTLE) ? SETTLE : stable_q + SW'(1);
    end
    cam_move = (stable_next >= SETTLE) && (quot_q != camera_y);
  end

  // Datapath and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rem_q         <= '0;
      quot_q        <= '0;
      last_target_q <= '0;
      stable_q      <= '0;
      anim_cnt_q    <= '0;
      camera_y      <= '0;
      char_id       <= '0;
      char_face     <= 2'b01;
      cam_update    <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      cam_update    <= 1'b0;
      frame_overrun <= frame_start && busy;

      if (accept) begin
        rem_q     <= {1'b0, char_abs_y} + HALF_H;
        quot_q    <= '0;
        char_face <= char_dir ? 2'b10 : 2'b01;
        if (!char_moving) begin
          char_id    <= '0;
          anim_cnt_q <= '0;
        end else if (anim_cnt_q == ANIM_LAST) begin
          anim_cnt_q <= '0;
          char_id    <= (char_id == ID_LAST) ? 3'd0 : char_id + 3'd1;
        end else begin
          anim_cnt_q <= anim_cnt_q + AW'(1);
        end
      end

      if (state_q == DIVIDE && div_step) begin
        rem_q  <= rem_q - BLOCK_W;
        quot_q <= quot_q + CAM_WIDTH'(1);
      end

      if (state_q == COMMIT) begin
        stable_q <= stable_next;
        if (!target_match) last_target_q <= quot_q;
        if (cam_move) begin
          camera_y   <= quot_q;
          cam_update <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_anim_controller.sv
module tb_camera_anim_controller;

  logic        sys_clk     = 1'b0;
  logic        sys_rst_n   = 1'b1;
  logic        frame_start = 1'b0;
  logic [13:0] char_abs_y  = '0;
  logic        char_moving = 1'b0;
  logic        char_dir    = 1'b0;
  logic [4:0]  camera_y;
  logic [2:0]  char_id;
  logic [1:0]  char_face;
  logic        cam_update;
  logic        busy;
  logic        frame_overrun;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state (spec-level quantities)
  int m_cam, m_last, m_stable, m_run;

  camera_anim_controller #(
    .PHY_WIDTH    (14),
    .BLOCK_WIDTH  (480),
    .CHAR_WIDTH_Y (52),
    .CAM_WIDTH    (5),
    .CAM_MAX      (31),
    .SETTLE_FRAMES(2),
    .ANIM_LEN     (7),
    .ANIM_FRAMES  (6)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .frame_start  (frame_start),
    .char_abs_y   (char_abs_y),
    .char_moving  (char_moving),
    .char_dir     (char_dir),
    .camera_y     (camera_y),
    .char_id      (char_id),
    .char_face    (char_face),
    .cam_update   (cam_update),
    .busy         (busy),
    .frame_overrun(frame_overrun)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int quot_of(input int y);
    int q;
    q = (y + 26) / 480;
    if (q > 31) q = 31;
    return q;
  endfunction

  task automatic model_reset;
    m_cam = 0; m_last = 0; m_stable = 0; m_run = 0;
  endtask

  task automatic do_reset(input string tag);
    frame_start = 1'b0;
    sys_rst_n   = 1'b0;
    tick;
    tick;
    chk($sformatf("%s camera_y", tag),      int'(camera_y), 0);
    chk($sformatf("%s char_id", tag),       int'(char_id), 0);
    chk($sformatf("%s char_face", tag),     int'(char_face), 1);
    chk($sformatf("%s cam_update", tag),    int'(cam_update), 0);
    chk($sformatf("%s busy", tag),          int'(busy), 0);
    chk($sformatf("%s frame_overrun", tag), int'(frame_overrun), 0);
    sys_rst_n = 1'b1;
    tick;
    model_reset();
  endtask

  // Runs one frame; ovr_at >= 0 injects a frame_start on that busy cycle.
  // char_abs_y is scrambled while busy to show the latched value is used.
  task automatic frame_and_check(input string tag, input int y, input bit mov,
                                 input bit dir, input int ovr_at,
                                 input int e_cam, input int e_upd,
                                 input int e_id, input int e_face,
                                 input int e_lat);
    int lat, upd_cnt, ovr_cnt;
    bit b0, upd_end, post_upd, post_ovr;
    char_abs_y  = 14'(y);
    char_moving = mov;
    char_dir    = dir;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    b0 = busy;
    lat = 0; upd_cnt = 0; ovr_cnt = 0;
    while (busy && lat < 200) begin
      char_abs_y = 14'($urandom_range(0, 16383));
      if (lat == ovr_at) begin
        frame_start = 1'b1;
        char_dir    = ~dir;
        char_moving = ~mov;
      end
      tick;
      frame_start = 1'b0;
      lat++;
      if (cam_update)    upd_cnt++;
      if (frame_overrun) ovr_cnt++;
    end
    upd_end = cam_update;
    tick;
    post_upd = cam_update;
    post_ovr = frame_overrun;
    chk($sformatf("%s busy_start", tag), int'(b0), 1);
    chk($sformatf("%s busy_cycles", tag), lat, e_lat);
    chk($sformatf("%s upd_count", tag), upd_cnt, e_upd);
    chk($sformatf("%s upd_at_idle", tag), int'(upd_end), e_upd);
    chk($sformatf("%s overrun_count", tag), ovr_cnt, (ovr_at >= 0) ? 1 : 0);
    chk($sformatf("%s upd_width", tag), int'(post_upd), 0);
    chk($sformatf("%s overrun_width", tag), int'(post_ovr), 0);
    chk($sformatf("%s camera_y", tag), int'(camera_y), e_cam);
    chk($sformatf("%s char_id", tag), int'(char_id), e_id);
    chk($sformatf("%s char_face", tag), int'(char_face), e_face);
  endtask

  task automatic model_frame(input string tag, input int y, input bit mov,
                             input bit dir, input int ovr_at);
    int q, e_upd;
    q = quot_of(y);
    if (q == m_last) begin
      if (m_stable < 2) m_stable++;
    end else begin
      m_last   = q;
      m_stable = 1;
    end
    e_upd = (m_stable >= 2 && q != m_cam) ? 1 : 0;
    if (e_upd == 1) m_cam = q;
    m_run = mov ? m_run + 1 : 0;
    frame_and_check(tag, y, mov, dir, ovr_at, m_cam, e_upd,
                    (m_run / 6) % 7, dir ? 2 : 1, q + 2);
  endtask

  typedef struct {
    int y;
    bit mov;
    bit dir;
    int cam;
    int upd;
    int id;
    int face;
    int lat;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int y, prev_y, k, q, ovr;
    bit mov, dir;

    // Sequence from reset, char_moving=1 throughout, direction alternating.
    tbl[0]  = '{1000,  1'b1, 1'b1, 0,  0, 0, 2, 4};
    tbl[1]  = '{1440,  1'b1, 1'b0, 0,  0, 0, 1, 5};
    tbl[2]  = '{1000,  1'b1, 1'b1, 0,  0, 0, 2, 4};
    tbl[3]  = '{1440,  1'b1, 1'b0, 0,  0, 0, 1, 5};
    tbl[4]  = '{1440,  1'b1, 1'b1, 3,  1, 0, 2, 5};
    tbl[5]  = '{1000,  1'b1, 1'b0, 3,  0, 1, 1, 4};
    tbl[6]  = '{1000,  1'b1, 1'b1, 2,  1, 1, 2, 4};
    tbl[7]  = '{454,   1'b1, 1'b0, 2,  0, 1, 1, 3};
    tbl[8]  = '{453,   1'b1, 1'b1, 2,  0, 1, 2, 2};
    tbl[9]  = '{453,   1'b1, 1'b0, 0,  1, 1, 1, 2};
    tbl[10] = '{16383, 1'b1, 1'b1, 0,  0, 1, 2, 33};
    tbl[11] = '{16383, 1'b1, 1'b0, 31, 1, 2, 1, 33};

    #1;
    do_reset("reset0");
    for (int i = 0; i < 12; i++) begin
      frame_and_check($sformatf("tbl%0d", i), tbl[i].y, tbl[i].mov, tbl[i].dir, -1,
                      tbl[i].cam, tbl[i].upd, tbl[i].id, tbl[i].face, tbl[i].lat);
    end

    // Walk animation: 42 moving frames wrap char_id, idle frame clears it.
    do_reset("reset_anim");
    for (int i = 1; i <= 42; i++) begin
      model_frame($sformatf("anim%0d", i), 0, 1'b1, i[0], -1);
      if (i == 6)  chk("anim_step6", int'(char_id), 1);
      if (i == 36) chk("anim_step36", int'(char_id), 6);
      if (i == 42) chk("anim_wrap42", int'(char_id), 0);
    end
    for (int i = 1; i <= 8; i++) begin
      model_frame($sformatf("anim_idle%0d", i), 0, (i > 1), 1'b0, -1);
    end

    // frame_start while busy, at several points in DIVIDE and in COMMIT.
    do_reset("reset_ovr");
    model_frame("ovr0", 16383, 1'b1, 1'b1, -1);
    model_frame("ovr1", 16383, 1'b1, 1'b0, 5);
    model_frame("ovr2", 1000,  1'b1, 1'b1, 0);
    model_frame("ovr3", 1000,  1'b0, 1'b0, 3);
    model_frame("ovr4", 1000,  1'b1, 1'b1, 2);

    // Asynchronous reset in the middle of DIVIDE.
    do_reset("reset_mid");
    model_frame("mid0", 1000, 1'b0, 1'b0, -1);
    model_frame("mid1", 1000, 1'b0, 1'b0, -1);
    char_abs_y  = 14'd16383;
    char_dir    = 1'b0;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    repeat (4) tick;
    chk("mid busy_before", int'(busy), 1);
    chk("mid camera_before", int'(camera_y), 2);
    sys_rst_n = 1'b0;
    #1;
    chk("mid camera_async", int'(camera_y), 0);
    chk("mid busy_async", int'(busy), 0);
    chk("mid upd_async", int'(cam_update), 0);
    chk("mid face_async", int'(char_face), 1);
    tick;
    tick;
    chk("mid upd_held", int'(cam_update), 0);
    sys_rst_n = 1'b1;
    tick;
    model_reset();
    model_frame("mid_after", 1000, 1'b0, 1'b1, -1);
    chk("mid face_right", int'(char_face), 2);

    // Randomised frames against the reference model.
    do_reset("reset_rnd");
    prev_y = 1000;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 4))
        0: y = int'($urandom_range(0, 16383));
        1: begin
          k = int'($urandom_range(1, 34));
          y = k * 480 - 26 - int'($urandom_range(0, 1));
        end
        2, 3: y = prev_y;
        default: y = int'($urandom_range(0, 2000));
      endcase
      prev_y = y;
      mov = ($urandom_range(0, 7) != 0);
      dir = 1'($urandom_range(0, 1));
      q = quot_of(y);
      ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, q + 1)) : -1;
      model_frame($sformatf("rnd%0d", i), y, mov, dir, ovr);
      repeat ($urandom_range(0, 3)) tick;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
